// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter: op encodings,
// datapath width and the arbiter state encoding.
package alu_arbiter_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLL = 3'b101;
    localparam logic [2:0] ALU_SRL = 3'b110;
    localparam logic [2:0] ALU_SRA = 3'b111;

    typedef enum logic {
        IDLE,
        EXEC
    } state_t;

    // True for the three shift encodings, whose b operand is a shift amount.
    function automatic logic is_shift(input logic [2:0] ctrl);
        return (ctrl == ALU_SLL) || (ctrl == ALU_SRL) || (ctrl == ALU_SRA);
    endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational integer ALU shared by both requesters of the arbiter.
// add/sub wrap modulo 2^W; shifts use only the low SHAMT_W bits of b.
module alu
    import alu_arbiter_pkg::*;
#(
    parameter int W       = XLEN,
    parameter int SHAMT_W = 5
) (
    input  logic [2:0]   ctrl_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] y_o
);

    logic [SHAMT_W-1:0] shamt;

    assign shamt = b_i[SHAMT_W-1:0];

    // Select the operation result for the current op code.
    always_comb begin
        y_o = '0;
        case (ctrl_i)
            ALU_ADD: y_o = a_i + b_i;
            ALU_SUB: y_o = a_i - b_i;
            ALU_AND: y_o = a_i & b_i;
            ALU_OR:  y_o = a_i | b_i;
            ALU_XOR: y_o = a_i ^ b_i;
            ALU_SLL: y_o = a_i << shamt;
            ALU_SRL: y_o = a_i >> shamt;
            ALU_SRA: y_o = $unsigned($signed(a_i) >>> shamt);
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// An accepted operation is latched in IDLE, executed during one EXEC cycle,
// and its result lands in the owner's one-deep response slot.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int W       = XLEN,
    parameter int SHAMT_W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [2:0]   req0_ctrl,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    output logic         rsp0_valid,
    input  logic         rsp0_ready,
    output logic [W-1:0] rsp0_data,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [2:0]   req1_ctrl,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    output logic         rsp1_valid,
    input  logic         rsp1_ready,
    output logic [W-1:0] rsp1_data,
    output logic         busy
);

    state_t       state_q, state_d;
    logic         last_grant_q, last_grant_d;
    logic         owner_q, owner_d;
    logic [2:0]   ctrl_q, ctrl_d;
    logic [W-1:0] a_q, a_d;
    logic [W-1:0] b_q, b_d;
    logic         rsp0_valid_q, rsp0_valid_d;
    logic [W-1:0] rsp0_data_q, rsp0_data_d;
    logic         rsp1_valid_q, rsp1_valid_d;
    logic [W-1:0] rsp1_data_q, rsp1_data_d;

    logic         elig0, elig1;
    logic         grant0, grant1;
    logic         acc0, acc1;
    logic [W-1:0] alu_b;
    logic [W-1:0] alu_y;

    // A requester whose response slot is still full cannot issue again,
    // so each requester has at most one operation in flight.
    assign elig0  = req0_valid & ~rsp0_valid_q;
    assign elig1  = req1_valid & ~rsp1_valid_q;

    // On a tie the requester that did not win last time gets the grant.
    assign grant0 = elig0 & (~elig1 | last_grant_q);
    assign grant1 = elig1 & (~elig0 | ~last_grant_q);

    assign req0_ready = (state_q == IDLE) & grant0;
    assign req1_ready = (state_q == IDLE) & grant1;
    assign acc0       = req0_valid & req0_ready;
    assign acc1       = req1_valid & req1_ready;

    // Shifts only see the low SHAMT_W bits of b; upper bits are ignored.
    assign alu_b = is_shift(ctrl_q) ? {{(W-SHAMT_W){1'b0}}, b_q[SHAMT_W-1:0]} : b_q;

    alu #(
        .W       (W),
        .SHAMT_W (SHAMT_W)
    ) u_alu (
        .ctrl_i (ctrl_q),
        .a_i    (a_q),
        .b_i    (alu_b),
        .y_o    (alu_y)
    );

    assign rsp0_valid = rsp0_valid_q;
    assign rsp0_data  = rsp0_data_q;
    assign rsp1_valid = rsp1_valid_q;
    assign rsp1_data  = rsp1_data_q;
    assign busy       = (state_q == EXEC);

    // Next-state logic: acceptance, execution and response-slot handshakes.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        ctrl_d       = ctrl_q;
        a_d          = a_q;
        b_d          = b_q;
        rsp0_valid_d = rsp0_valid_q;
        rsp0_data_d  = rsp0_data_q;
        rsp1_valid_d = rsp1_valid_q;
        rsp1_data_d  = rsp1_data_q;

        // Consumption; the data word is deliberately kept after it is read.
        if (rsp0_valid_q && rsp0_ready) begin
            rsp0_valid_d = 1'b0;
        end
        if (rsp1_valid_q && rsp1_ready) begin
            rsp1_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (acc0) begin
                    ctrl_d       = req0_ctrl;
                    a_d          = req0_a;
                    b_d          = req0_b;
                    owner_d      = 1'b0;
                    last_grant_d = 1'b0;
                    state_d      = EXEC;
                end else if (acc1) begin
                    ctrl_d       = req1_ctrl;
                    a_d          = req1_a;
                    b_d          = req1_b;
                    owner_d      = 1'b1;
                    last_grant_d = 1'b1;
                    state_d      = EXEC;
                end
            end
            EXEC: begin
                // The owner's slot is known empty here, so setting it never
                // collides with a consumption on the same edge.
                if (owner_q) begin
                    rsp1_valid_d = 1'b1;
                    rsp1_data_d  = alu_y;
                end else begin
                    rsp0_valid_d = 1'b1;
                    rsp0_data_d  = alu_y;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; reset discards any operation in EXEC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            ctrl_q       <= '0;
            a_q          <= '0;
            b_q          <= '0;
            rsp0_valid_q <= 1'b0;
            rsp0_data_q  <= '0;
            rsp1_valid_q <= 1'b0;
            rsp1_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            ctrl_q       <= ctrl_d;
            a_q          <= a_d;
            b_q          <= b_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp0_data_q  <= rsp0_data_d;
            rsp1_valid_q <= rsp1_valid_d;
            rsp1_data_q  <= rsp1_data_d;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: expected results are queued per
// requester when an operation is driven and popped when its response shows.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid = 1'b0;
    logic        req0_ready;
    logic [2:0]  req0_ctrl = 3'b000;
    logic [31:0] req0_a = '0;
    logic [31:0] req0_b = '0;
    logic        rsp0_valid;
    logic        rsp0_ready = 1'b0;
    logic [31:0] rsp0_data;
    logic        req1_valid = 1'b0;
    logic        req1_ready;
    logic [2:0]  req1_ctrl = 3'b000;
    logic [31:0] req1_a = '0;
    logic [31:0] req1_b = '0;
    logic        rsp1_valid;
    logic        rsp1_ready = 1'b0;
    logic [31:0] rsp1_data;
    logic        busy;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp0[$];
    logic [31:0] exp1[$];
    logic [31:0] want;

    always #5 clk = ~clk;

    alu_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_ctrl  (req0_ctrl),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .rsp0_valid (rsp0_valid),
        .rsp0_ready (rsp0_ready),
        .rsp0_data  (rsp0_data),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_ctrl  (req1_ctrl),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp1_valid (rsp1_valid),
        .rsp1_ready (rsp1_ready),
        .rsp1_data  (rsp1_data),
        .busy       (busy)
    );

    // Reference model: sra is built from an explicit sign-extended word.
    function automatic logic [31:0] model(input logic [2:0] c, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [4:0]  sh;
        logic [63:0] ext;
        sh = b[4:0];
        case (c)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return a << sh;
            3'd6: return a >> sh;
            default: begin
                ext = {{32{a[31]}}, a};
                ext = ext >> sh;
                return ext[31:0];
            end
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
        checks++; if (rsp0_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp0_valid got=%b want=0", rsp0_valid); end
        checks++; if (rsp1_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp1_valid got=%b want=0", rsp1_valid); end
        checks++; if (rsp0_data !== 32'h0) begin failures++; $display("FAIL reset_rsp0_data got=%h want=0", rsp0_data); end
        checks++; if (rsp1_data !== 32'h0) begin failures++; $display("FAIL reset_rsp1_data got=%h want=0", rsp1_data); end
        tick();
        rst = 1'b0;
        #1;
        checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            failures++; $display("FAIL reset_ready got=%b%b want=00", req0_ready, req1_ready);
        end
    endtask

    task automatic test_single_add();
        tick();
        req0_ctrl = 3'b000; req0_a = 32'd5; req0_b = 32'd4; req0_valid = 1'b1;
        exp0.push_back(model(req0_ctrl, req0_a, req0_b));
        #1;
        checks++; if (req0_ready !== 1'b1) begin failures++; $display("FAIL add_req0_ready got=%b want=1", req0_ready); end
        checks++; if (req1_ready !== 1'b0) begin failures++; $display("FAIL add_req1_ready got=%b want=0", req1_ready); end
        tick();
        req0_valid = 1'b0;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL add_busy_exec got=%b want=1", busy); end
        checks++; if (rsp0_valid !== 1'b0) begin failures++; $display("FAIL add_rsp0_early got=%b want=0", rsp0_valid); end
        tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL add_busy_after got=%b want=0", busy); end
        checks++; if (rsp0_valid !== 1'b1) begin failures++; $display("FAIL add_rsp0_valid got=%b want=1", rsp0_valid); end
        if (rsp0_valid === 1'b1) begin
            want = exp0.pop_front();
            checks++; if (rsp0_data !== want) begin failures++; $display("FAIL add_rsp0_data got=%h want=%h", rsp0_data, want); end
        end
        rsp0_ready = 1'b1;
        tick();
        rsp0_ready = 1'b0;
        checks++; if (rsp0_valid !== 1'b0) begin failures++; $display("FAIL add_consume got=%b want=0", rsp0_valid); end
        checks++; if (rsp0_data !== 32'd9) begin failures++; $display("FAIL add_retained got=%h want=9", rsp0_data); end
    endtask

    task automatic test_both_alternate();
        int gr[$];
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp0.delete(); exp1.delete();
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        req0_ctrl = 3'b001; req0_a = 32'd13;  req0_b = 32'd66;  req0_valid = 1'b1;
        req1_ctrl = 3'b100; req1_a = 32'd749; req1_b = 32'd619; req1_valid = 1'b1;
        exp0.push_back(model(req0_ctrl, req0_a, req0_b));
        exp1.push_back(model(req1_ctrl, req1_a, req1_b));
        #1;
        checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            failures++; $display("FAIL both_first_grant got=%b%b want=10", req0_ready, req1_ready);
        end
        tick();
        req0_valid = 1'b0;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL both_busy got=%b want=1", busy); end
        tick();
        checks++; if (rsp0_valid !== 1'b1) begin failures++; $display("FAIL both_rsp0_valid got=%b want=1", rsp0_valid); end
        want = exp0.pop_front();
        checks++; if (rsp0_data !== want || rsp0_data !== 32'hFFFFFFCB) begin
            failures++; $display("FAIL both_rsp0_data got=%h want=%h", rsp0_data, want);
        end
        checks++; if (req1_ready !== 1'b1) begin failures++; $display("FAIL both_req1_ready got=%b want=1", req1_ready); end
        tick();
        req1_valid = 1'b0;
        checks++; if (rsp0_valid !== 1'b0 || busy !== 1'b1) begin
            failures++; $display("FAIL both_second_exec got=rsp0v %b busy %b want=0 1", rsp0_valid, busy);
        end
        tick();
        checks++; if (rsp1_valid !== 1'b1) begin failures++; $display("FAIL both_rsp1_valid got=%b want=1", rsp1_valid); end
        want = exp1.pop_front();
        checks++; if (rsp1_data !== want || rsp1_data !== 32'd134) begin
            failures++; $display("FAIL both_rsp1_data got=%h want=%h", rsp1_data, want);
        end
        tick();
        // Continuous traffic from both sides.
        req0_ctrl = 3'b010; req0_a = 32'hFFFF00FF; req0_b = 32'h0F0F0F0F; req0_valid = 1'b1;
        req1_ctrl = 3'b011; req1_a = 32'h00001200; req1_b = 32'h00000034; req1_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (c == 14) begin req0_valid = 1'b0; req1_valid = 1'b0; end
            #1;
            if (rsp0_valid === 1'b1) begin
                checks++;
                if (exp0.size() == 0) begin failures++; $display("FAIL alt_rsp0_unexpected got=%h want=none", rsp0_data); end
                else begin
                    want = exp0.pop_front();
                    if (rsp0_data !== want) begin failures++; $display("FAIL alt_rsp0_data got=%h want=%h", rsp0_data, want); end
                end
            end
            if (rsp1_valid === 1'b1) begin
                checks++;
                if (exp1.size() == 0) begin failures++; $display("FAIL alt_rsp1_unexpected got=%h want=none", rsp1_data); end
                else begin
                    want = exp1.pop_front();
                    if (rsp1_data !== want) begin failures++; $display("FAIL alt_rsp1_data got=%h want=%h", rsp1_data, want); end
                end
            end
            checks++; if (req0_ready === 1'b1 && req1_ready === 1'b1) begin
                failures++; $display("FAIL alt_dual_grant got=11 want=one-hot");
            end
            if (req0_ready === 1'b1) begin exp0.push_back(model(req0_ctrl, req0_a, req0_b)); gr.push_back(0); end
            if (req1_ready === 1'b1) begin exp1.push_back(model(req1_ctrl, req1_a, req1_b)); gr.push_back(1); end
            tick();
        end
        checks++; if (gr.size() < 6) begin failures++; $display("FAIL alt_grant_count got=%0d want>=6", gr.size()); end
        for (int k = 0; k < gr.size(); k++) begin
            checks++; if (gr[k] != (k % 2)) begin failures++; $display("FAIL alt_order idx=%0d got=%0d want=%0d", k, gr[k], k % 2); end
        end
        checks++; if (exp0.size() != 0 || exp1.size() != 0) begin
            failures++; $display("FAIL alt_drain got=%0d/%0d pending want=0/0", exp0.size(), exp1.size());
        end
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    endtask

    task automatic test_shifts();
        logic [2:0]  ops[2];
        logic [31:0] lit[2];
        ops[0] = 3'b111; lit[0] = 32'hF8000000;
        ops[1] = 3'b110; lit[1] = 32'h08000000;
        for (int i = 0; i < 2; i++) begin
            req1_ctrl = ops[i]; req1_a = 32'h80000000; req1_b = 32'h00000024; req1_valid = 1'b1;
            exp1.push_back(model(req1_ctrl, req1_a, req1_b));
            #1;
            checks++; if (req1_ready !== 1'b1) begin failures++; $display("FAIL shift%0d_ready got=%b want=1", i, req1_ready); end
            tick();
            req1_valid = 1'b0;
            tick();
            checks++; if (rsp1_valid !== 1'b1) begin failures++; $display("FAIL shift%0d_valid got=%b want=1", i, rsp1_valid); end
            want = exp1.pop_front();
            checks++; if (rsp1_data !== want || rsp1_data !== lit[i]) begin
                failures++; $display("FAIL shift%0d_data got=%h want=%h", i, rsp1_data, lit[i]);
            end
            rsp1_ready = 1'b1;
            tick();
            rsp1_ready = 1'b0;
        end
    endtask

    task automatic test_backpressure();
        int acc;
        rsp0_ready = 1'b0; rsp1_ready = 1'b1;
        req0_ctrl = 3'b010; req0_a = 32'h0000F0F0; req0_b = 32'h0000FF00; req0_valid = 1'b1;
        exp0.push_back(model(req0_ctrl, req0_a, req0_b));
        #1;
        checks++; if (req0_ready !== 1'b1) begin failures++; $display("FAIL bp_first_ready got=%b want=1", req0_ready); end
        tick();
        req0_ctrl = 3'b011; req0_a = 32'h000000A0; req0_b = 32'h00000005;
        tick();
        want = exp0.pop_front();
        checks++; if (rsp0_valid !== 1'b1 || rsp0_data !== want) begin
            failures++; $display("FAIL bp_first_rsp got=%b/%h want=1/%h", rsp0_valid, rsp0_data, want);
        end
        req1_ctrl = 3'b000; req1_a = 32'd100; req1_b = 32'd23; req1_valid = 1'b1;
        acc = 0;
        for (int c = 0; c < 12; c++) begin
            if (acc >= 2) req1_valid = 1'b0;
            #1;
            checks++; if (req0_ready !== 1'b0 || rsp0_valid !== 1'b1 || rsp0_data !== 32'h0000F000) begin
                failures++; $display("FAIL bp_hold cyc=%0d got=rdy %b v %b d %h want=0 1 0000f000", c, req0_ready, rsp0_valid, rsp0_data);
            end
            if (rsp1_valid === 1'b1) begin
                checks++;
                if (exp1.size() == 0) begin failures++; $display("FAIL bp_rsp1_unexpected got=%h want=none", rsp1_data); end
                else begin
                    want = exp1.pop_front();
                    if (rsp1_data !== want) begin failures++; $display("FAIL bp_rsp1_data got=%h want=%h", rsp1_data, want); end
                end
            end
            if (req1_ready === 1'b1) begin exp1.push_back(model(req1_ctrl, req1_a, req1_b)); acc++; end
            tick();
        end
        checks++; if (acc != 2 || exp1.size() != 0) begin
            failures++; $display("FAIL bp_req1_served got=%0d pending=%0d want=2 pending=0", acc, exp1.size());
        end
        rsp0_ready = 1'b1;
        tick();
        rsp0_ready = 1'b0;
        #1;
        checks++; if (rsp0_valid !== 1'b0 || req0_ready !== 1'b1) begin
            failures++; $display("FAIL bp_release got=v %b rdy %b want=0 1", rsp0_valid, req0_ready);
        end
        exp0.push_back(model(req0_ctrl, req0_a, req0_b));
        tick();
        req0_valid = 1'b0;
        tick();
        want = exp0.pop_front();
        checks++; if (rsp0_valid !== 1'b1 || rsp0_data !== want) begin
            failures++; $display("FAIL bp_second_rsp got=%b/%h want=1/%h", rsp0_valid, rsp0_data, want);
        end
        rsp0_ready = 1'b1;
        tick();
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    endtask

    task automatic test_reset_mid_exec();
        req0_ctrl = 3'b011; req0_a = 32'h00000F00; req0_b = 32'h000000F0; req0_valid = 1'b1;
        tick();
        req0_valid = 1'b0;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rstx_busy got=%b want=1", busy); end
        #1;
        rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstx_async_busy got=%b want=0", busy); end
        tick();
        rst = 1'b0;
        tick();
        checks++; if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL rstx_no_rsp got=%b%b busy %b want=00 busy 0", rsp0_valid, rsp1_valid, busy);
        end
        checks++; if (rsp0_data !== 32'h0 || rsp1_data !== 32'h0) begin
            failures++; $display("FAIL rstx_data got=%h/%h want=0/0", rsp0_data, rsp1_data);
        end
        req0_ctrl = 3'b000; req0_a = 32'd7; req0_b = 32'd8; req0_valid = 1'b1;
        req1_ctrl = 3'b100; req1_a = 32'd3; req1_b = 32'd5; req1_valid = 1'b1;
        #1;
        checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            failures++; $display("FAIL rstx_grant got=%b%b want=10", req0_ready, req1_ready);
        end
        exp0.push_back(model(req0_ctrl, req0_a, req0_b));
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
        want = exp0.pop_front();
        checks++; if (rsp0_valid !== 1'b1 || rsp0_data !== want) begin
            failures++; $display("FAIL rstx_after got=%b/%h want=1/%h", rsp0_valid, rsp0_data, want);
        end
        rsp0_ready = 1'b1;
        tick();
        rsp0_ready = 1'b0;
    endtask

    task automatic test_wrap();
        logic [2:0]  ops[4];
        logic [31:0] av[4];
        logic [31:0] bv[4];
        logic [31:0] lit[4];
        ops[0] = 3'b000; av[0] = 32'hFFFFFFFF; bv[0] = 32'd1;        lit[0] = 32'h00000000;
        ops[1] = 3'b101; av[1] = 32'd1;        bv[1] = 32'd31;       lit[1] = 32'h80000000;
        ops[2] = 3'b101; av[2] = 32'd1;        bv[2] = 32'h0000003F; lit[2] = 32'h80000000;
        ops[3] = 3'b001; av[3] = 32'd0;        bv[3] = 32'd1;        lit[3] = 32'hFFFFFFFF;
        for (int i = 0; i < 4; i++) begin
            req0_ctrl = ops[i]; req0_a = av[i]; req0_b = bv[i]; req0_valid = 1'b1;
            exp0.push_back(model(req0_ctrl, req0_a, req0_b));
            #1;
            checks++; if (req0_ready !== 1'b1) begin failures++; $display("FAIL wrap%0d_ready got=%b want=1", i, req0_ready); end
            tick();
            req0_valid = 1'b0;
            tick();
            want = exp0.pop_front();
            checks++; if (rsp0_valid !== 1'b1 || rsp0_data !== want || rsp0_data !== lit[i]) begin
                failures++; $display("FAIL wrap%0d_data got=%b/%h want=1/%h", i, rsp0_valid, rsp0_data, lit[i]);
            end
            rsp0_ready = 1'b1;
            tick();
            rsp0_ready = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_both_alternate();
        test_shifts();
        test_backpressure();
        test_reset_mid_exec();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
